pwm_multi: RTL and testbench
============================

Name: pwm_multi

Overview:
- Parametrised multi-channel successor to the single-channel PWM.
- One shared period counter drives CHANNELS compare outputs, each with its own duty and output polarity.
- Period and duty values are double-buffered: new values take effect only at a period boundary, so outputs never glitch.
- Stop is graceful (drains to the end of the current period); sits between the control register block and the output pins.

Parameters:
- WIDTH, 16, bit width of the counter, period and each duty value.
- CHANNELS, 4, number of PWM outputs.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  level; begin or continue generation.
- stop  input  1  level; request graceful stop.
- update  input  1  one-cycle pulse; request that new period/active values be loaded at the next period boundary.
- period  input  WIDTH  period in clocks.
- active  input  CHANNELS*WIDTH  duty (high count) per channel; channel i occupies bits [i*WIDTH +: WIDTH].
- polarity  input  CHANNELS  1 inverts channel i; sampled continuously.
- pulse  output  CHANNELS  PWM outputs, registered.
- period_end  output  1  high during the last count of each period, registered.
- running  output  1  high in RUN or DRAIN, registered.

Behaviour:
- Asynchronous reset (reset=0) forces: state IDLE, cnt=0, shadow registers=0, update_pending=0, pulse=polarity, period_end=0, running=0.
- FSM states: IDLE, RUN, DRAIN.
  - IDLE, start=1 and stop=0 at an edge: go to RUN; cnt<=0; period_s<=period; active_s<=active; update_pending<=0.
  - RUN, stop=1: go to DRAIN. stop has priority over start.
  - DRAIN, start=1 and stop=0: return to RUN; the count is not restarted.
  - DRAIN, edge where cnt==period_s-1: go to IDLE; cnt<=0.
  - IDLE with both start=1 and stop=1: remain in IDLE.
- Effective period: P = max(period_s, 1). A period of 0 behaves as 1.
- Counter: in RUN/DRAIN, cnt counts 0..P-1 and then wraps to 0. It is held at 0 in IDLE.
- Double-buffer update:
  - update=1 in any state sets update_pending.
  - At a wrap edge with update_pending=1, period_s and active_s load from the inputs and update_pending clears.
  - update on the same edge as a wrap sets pending only; the load happens at the following wrap.
  - Inputs are ignored otherwise.
- Outputs are aligned with cnt (computed from next-state values, so there is zero added latency relative to cnt):
  - pulse[i] = ((cnt < active_s[i]) ^ polarity[i]) in RUN/DRAIN; pulse[i] = polarity[i] in IDLE.
  - active_s[i]=0 gives constant inactive level; active_s[i] >= P gives constant active level.
  - The first active cycle is the cycle immediately after the edge that sampled start.
- period_end = 1 exactly when cnt==P-1 in RUN/DRAIN; with P=1 it is high every running cycle.
- running = 1 in RUN or DRAIN.
- Comparisons are unsigned, WIDTH bits wide. The counter must never exceed P-1, including when period_s shrinks at a load: the load occurs only at wrap, where cnt is already 0.
- Reset asserted mid-period: all outputs go to their reset values immediately (asynchronously). After release the block is in IDLE and needs a new start.

Test Plan:
- Basic run: CHANNELS=4, period=10, active={4,0,10,12}, polarity=0, start held from cycle 0.
  - ch0 high 4 / low 6.
  - ch1 constant 0.
  - ch2 and ch3 constant 1.
  - period_end high every 10th cycle (cnt=9).
- Polarity: same stimulus with polarity=4'b0001 -> ch0 low 4 / high 6; in IDLE, ch0 idles high.
- Shadow update: running period=10, active0=4; mid-period (cnt=3) set period=6, active0=2 and pulse update.
  - Current period completes as 4/6.
  - Next period is 2 high / 4 low, period_end every 6 cycles.
  - Changing inputs without update has no effect.
- Graceful stop: assert stop at cnt=2.
  - Output continues through cnt=9.
  - running drops and pulse returns to polarity at the next cycle.
  - Re-asserting start with stop=0 during DRAIN keeps the counter running without restart.
- Boundaries:
  - period=0 and period=1: period_end high every cycle; active0=1 gives constant high, active0=0 gives constant low.
  - start and stop both asserted from IDLE: stays IDLE.
- Reset mid-operation: drop reset at cnt=5.
  - pulse=polarity, running=0, period_end=0 immediately (no clock edge needed).
  - After release, no output until start.

Source files
------------

// File: rtl/pwm_multi.sv
// rtl/pwm_multi.sv - multi-channel PWM with shared period counter and double-buffered settings
//
// Purpose: one period counter drives CHANNELS compare outputs. Period and duty
// values are loaded into shadow registers only at a period boundary, so an
// output never glitches mid-period. Stop drains to the end of the current period.
//
// Ports:
//   clk        - system clock, rising edge
//   reset      - asynchronous active-low reset
//   start      - level; begin or continue generation
//   stop       - level; graceful stop request (wins over start)
//   update     - pulse; load period/active at the next period boundary
//   period     - period in clocks (0 behaves as 1)
//   active     - per-channel high count, channel i at [i*WIDTH +: WIDTH]
//   polarity   - per-channel output inversion, applied continuously
//   pulse      - PWM outputs
//   period_end - high during the last count of each period
//   running    - high while generating or draining

module pwm_multi #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      stop,
  input  logic                      update,
  input  logic [WIDTH-1:0]          period,
  input  logic [CHANNELS*WIDTH-1:0] active,
  input  logic [CHANNELS-1:0]       polarity,
  output logic [CHANNELS-1:0]       pulse,
  output logic                      period_end,
  output logic                      running
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [1:0]                state_q, state_d;
  logic [WIDTH-1:0]          cnt_q, cnt_d;
  logic [WIDTH-1:0]          period_s_q, period_s_d;
  logic [CHANNELS*WIDTH-1:0] active_s_q, active_s_d;
  logic                      pend_q, pend_d;
  logic [CHANNELS-1:0]       cmp_q, cmp_d;
  logic                      pe_q, pe_d;
  logic                      run_q, run_d;
  logic                      wrap;
  logic                      go;

  // Last count of a period; a programmed period of 0 behaves as 1.
  function automatic logic [WIDTH-1:0] last_count(input logic [WIDTH-1:0] p);
    return (p == '0) ? '0 : p - ONE;
  endfunction

  always_comb begin
    go         = start && !stop;
    wrap       = (state_q != ST_IDLE) && (cnt_q == last_count(period_s_q));
    state_d    = state_q;
    cnt_d      = cnt_q;
    period_s_d = period_s_q;
    active_s_d = active_s_q;
    // An update coinciding with a wrap only arms the load for the next wrap.
    pend_d     = update || (pend_q && !wrap);

    if (wrap && pend_q) begin
      period_s_d = period;
      active_s_d = active;
    end

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (go) begin
          state_d    = ST_RUN;
          period_s_d = period;
          active_s_d = active;
          pend_d     = 1'b0;
        end
      end
      ST_RUN: begin
        cnt_d = wrap ? '0 : cnt_q + ONE;
        if (stop) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        cnt_d = wrap ? '0 : cnt_q + ONE;
        // Resuming keeps the count; it takes priority over finishing the drain.
        if (go)        state_d = ST_RUN;
        else if (wrap) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Outputs are derived from next-state values so they line up with cnt_q.
    run_d = (state_d != ST_IDLE);
    pe_d  = run_d && (cnt_d == last_count(period_s_d));
    cmp_d = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      cmp_d[i] = run_d && (cnt_d < active_s_d[i*WIDTH +: WIDTH]);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      period_s_q <= '0;
      active_s_q <= '0;
      pend_q     <= 1'b0;
      cmp_q      <= '0;
      pe_q       <= 1'b0;
      run_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      period_s_q <= period_s_d;
      active_s_q <= active_s_d;
      pend_q     <= pend_d;
      cmp_q      <= cmp_d;
      pe_q       <= pe_d;
      run_q      <= run_d;
    end
  end

  // cmp_q is zero whenever not running, so idle/reset level is the polarity.
  assign pulse      = cmp_q ^ polarity;
  assign period_end = pe_q;
  assign running    = run_q;

endmodule

// File: tb/tb_pwm_multi.sv
// tb/tb_pwm_multi.sv - self-checking bench for pwm_multi

module tb_pwm_multi;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        stop;
  logic        update;
  logic [15:0] period;
  logic [63:0] active;
  logic [3:0]  polarity;
  logic [3:0]  pulse;
  logic        period_end;
  logic        running;

  int checks   = 0;
  int failures = 0;

  pwm_multi #(.WIDTH(16), .CHANNELS(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .stop       (stop),
    .update     (update),
    .period     (period),
    .active     (active),
    .polarity   (polarity),
    .pulse      (pulse),
    .period_end (period_end),
    .running    (running)
  );

  always #5 clk = ~clk;

  // Reference model: position within the period plus on/draining flags.
  bit m_on;
  bit m_drain;
  bit m_pend;
  int m_pos;
  int m_per;
  int m_act[4];

  task automatic model_reset();
    m_on = 0; m_drain = 0; m_pend = 0; m_pos = 0; m_per = 0;
    for (int i = 0; i < 4; i++) m_act[i] = 0;
  endtask

  task automatic model_load();
    m_per = int'(period);
    for (int i = 0; i < 4; i++) m_act[i] = int'(active[i*16 +: 16]);
  endtask

  function automatic int m_len();
    return (m_per < 1) ? 1 : m_per;
  endfunction

  task automatic model_edge();
    bit at_end;
    bit go;
    if (!reset) begin
      model_reset();
      return;
    end
    at_end = m_on && (m_pos == m_len() - 1);
    go     = start && !stop;
    if (!m_on) begin
      if (go) begin
        m_on = 1; m_drain = 0; m_pos = 0; m_pend = 0;
        model_load();
      end else if (update) begin
        m_pend = 1;
      end
    end else begin
      if (at_end && m_pend) begin
        model_load();
        m_pend = 0;
      end
      if (update) m_pend = 1;
      m_pos = at_end ? 0 : m_pos + 1;
      if (!m_drain) begin
        if (stop) m_drain = 1;
      end else if (go) begin
        m_drain = 0;
      end else if (at_end) begin
        m_on = 0;
        m_pos = 0;
      end
    end
  endtask

  function automatic logic [3:0] m_pulse();
    logic [3:0] r;
    for (int i = 0; i < 4; i++) begin
      r[i] = m_on ? (((m_pos < m_act[i]) ? 1'b1 : 1'b0) ^ polarity[i]) : polarity[i];
    end
    return r;
  endfunction

  function automatic logic m_pe();
    return m_on && (m_pos == m_len() - 1);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_chk();
    chk("model_pulse", {60'd0, pulse}, {60'd0, m_pulse()});
    chk("model_period_end", {63'd0, period_end}, {63'd0, m_pe()});
    chk("model_running", {63'd0, running}, {63'd0, m_on});
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    model_chk();
  endtask

  task automatic set_act(input int a0, input int a1, input int a2, input int a3);
    active = {a3[15:0], a2[15:0], a1[15:0], a0[15:0]};
  endtask

  task automatic go_idle();
    start = 0; stop = 1;
    repeat (25) cyc();
    stop = 0;
    chk("go_idle_running", {63'd0, running}, 64'd0);
  endtask

  typedef struct {
    logic       st;
    logic       sp;
    logic [3:0] pol;
    logic [3:0] e_pulse;
    logic       e_pe;
    logic       e_run;
  } vec_t;

  vec_t tbl[16];

  initial begin
    reset = 0; start = 0; stop = 0; update = 0;
    period = 16'd10; active = '0; polarity = 4'b0000;
    model_reset();

    // Reset state, polarity passes through while held in reset.
    #2;
    chk("reset_pulse", {60'd0, pulse}, 64'd0);
    chk("reset_pe", {63'd0, period_end}, 64'd0);
    chk("reset_running", {63'd0, running}, 64'd0);
    polarity = 4'b1010;
    #1;
    chk("reset_pulse_pol", {60'd0, pulse}, 64'ha);
    polarity = 4'b0000;
    @(posedge clk);
    #1 reset = 1;

    // Table: period 3, active {2,0,3,5}; pulse bits are {ch3,ch2,ch1,ch0}.
    tbl[0]  = '{1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 4'b0000, 4'b1101, 1'b0, 1'b1};
    tbl[2]  = '{1'b1, 1'b0, 4'b0000, 4'b1101, 1'b0, 1'b1};
    tbl[3]  = '{1'b1, 1'b0, 4'b0000, 4'b1100, 1'b1, 1'b1};
    tbl[4]  = '{1'b1, 1'b0, 4'b0000, 4'b1101, 1'b0, 1'b1};
    tbl[5]  = '{1'b1, 1'b1, 4'b0000, 4'b1101, 1'b0, 1'b1};
    tbl[6]  = '{1'b0, 1'b0, 4'b0000, 4'b1100, 1'b1, 1'b1};
    tbl[7]  = '{1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0};
    tbl[8]  = '{1'b1, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0};
    tbl[9]  = '{1'b1, 1'b0, 4'b0000, 4'b1101, 1'b0, 1'b1};
    tbl[10] = '{1'b0, 1'b1, 4'b0000, 4'b1101, 1'b0, 1'b1};
    tbl[11] = '{1'b1, 1'b0, 4'b0000, 4'b1100, 1'b1, 1'b1};
    tbl[12] = '{1'b1, 1'b0, 4'b0000, 4'b1101, 1'b0, 1'b1};
    tbl[13] = '{1'b1, 1'b0, 4'b0011, 4'b1110, 1'b0, 1'b1};
    tbl[14] = '{1'b0, 1'b1, 4'b0011, 4'b1111, 1'b1, 1'b1};
    tbl[15] = '{1'b0, 1'b0, 4'b0011, 4'b0011, 1'b0, 1'b0};
    period = 16'd3;
    set_act(2, 0, 3, 5);
    for (int r = 0; r < 16; r++) begin
      start = tbl[r].st; stop = tbl[r].sp; polarity = tbl[r].pol;
      cyc();
      chk($sformatf("tbl%0d_pulse", r), {60'd0, pulse}, {60'd0, tbl[r].e_pulse});
      chk($sformatf("tbl%0d_pe", r), {63'd0, period_end}, {63'd0, tbl[r].e_pe});
      chk($sformatf("tbl%0d_run", r), {63'd0, running}, {63'd0, tbl[r].e_run});
    end
    start = 0; stop = 0; polarity = 4'b0000;

    // Basic run.
    period = 16'd10;
    set_act(4, 0, 10, 12);
    start = 1;
    for (int k = 0; k < 22; k++) begin
      cyc();
      chk("basic_ch0", {63'd0, pulse[0]}, {63'd0, (k % 10) < 4});
      chk("basic_ch321", {61'd0, pulse[3:1]}, 64'd6);
      chk("basic_pe", {63'd0, period_end}, {63'd0, (k % 10) == 9});
    end
    go_idle();

    // Polarity on channel 0.
    polarity = 4'b0001;
    #1;
    chk("pol_idle_high", {63'd0, pulse[0]}, 64'd1);
    start = 1;
    for (int k = 0; k < 20; k++) begin
      cyc();
      chk("pol_ch0", {63'd0, pulse[0]}, {63'd0, !((k % 10) < 4)});
    end
    go_idle();
    chk("pol_idle_again", {63'd0, pulse[0]}, 64'd1);
    polarity = 4'b0000;

    // Shadow update mid-period, then input changes without update.
    period = 16'd10;
    set_act(4, 0, 10, 12);
    start = 1;
    for (int k = 0; k < 28; k++) begin
      cyc();
      if (k < 10) begin
        chk("shadow_ch0", {63'd0, pulse[0]}, {63'd0, k < 4});
        chk("shadow_pe", {63'd0, period_end}, {63'd0, k == 9});
      end else begin
        chk("shadow_ch0_new", {63'd0, pulse[0]}, {63'd0, ((k - 10) % 6) < 2});
        chk("shadow_pe_new", {63'd0, period_end}, {63'd0, ((k - 10) % 6) == 5});
      end
      if (k == 3) begin
        period = 16'd6;
        set_act(2, 0, 10, 12);
        update = 1;
      end else begin
        update = 0;
      end
      if (k == 12) begin
        period = 16'd8;
        set_act(5, 0, 10, 12);
      end
    end
    go_idle();

    // Graceful stop at cnt=2.
    period = 16'd10;
    set_act(4, 0, 10, 12);
    start = 1;
    for (int k = 0; k < 12; k++) begin
      cyc();
      if (k <= 9) begin
        chk("stop_running", {63'd0, running}, 64'd1);
        chk("stop_ch0", {63'd0, pulse[0]}, {63'd0, k < 4});
      end else begin
        chk("stop_idle_running", {63'd0, running}, 64'd0);
        chk("stop_idle_pulse", {60'd0, pulse}, 64'd0);
        chk("stop_idle_pe", {63'd0, period_end}, 64'd0);
      end
      if (k == 2) begin start = 0; stop = 1; end
    end
    stop = 0;

    // Resume during drain keeps counting.
    start = 1;
    for (int k = 0; k < 15; k++) begin
      cyc();
      chk("resume_running", {63'd0, running}, 64'd1);
      chk("resume_ch0", {63'd0, pulse[0]}, {63'd0, (k % 10) < 4});
      chk("resume_pe", {63'd0, period_end}, {63'd0, (k % 10) == 9});
      if (k == 2) begin start = 0; stop = 1; end
      if (k == 4) begin start = 1; stop = 0; end
    end
    go_idle();

    // Period 0 and period 1.
    period = 16'd0;
    set_act(1, 0, 0, 0);
    start = 1;
    for (int k = 0; k < 5; k++) begin
      cyc();
      chk("p0_pe", {63'd0, period_end}, 64'd1);
      chk("p0_ch0", {63'd0, pulse[0]}, 64'd1);
    end
    go_idle();
    period = 16'd1;
    set_act(0, 0, 0, 0);
    start = 1;
    for (int k = 0; k < 5; k++) begin
      cyc();
      chk("p1_pe", {63'd0, period_end}, 64'd1);
      chk("p1_ch0", {63'd0, pulse[0]}, 64'd0);
    end
    go_idle();

    // Asynchronous reset mid-period.
    polarity = 4'b0101;
    period = 16'd10;
    set_act(4, 0, 10, 12);
    start = 1;
    for (int k = 0; k < 6; k++) cyc();
    #1 reset = 0;
    #1;
    model_reset();
    chk("areset_pulse", {60'd0, pulse}, 64'h5);
    chk("areset_running", {63'd0, running}, 64'd0);
    chk("areset_pe", {63'd0, period_end}, 64'd0);
    start = 0;
    @(negedge clk);
    reset = 1;
    for (int k = 0; k < 5; k++) begin
      cyc();
      chk("post_reset_idle", {63'd0, running}, 64'd0);
      chk("post_reset_pulse", {60'd0, pulse}, 64'h5);
    end

    // Randomized run against the model.
    for (int n = 0; n < 3000; n++) begin
      start  = ($urandom_range(0, 3) != 0);
      stop   = ($urandom_range(0, 7) == 0);
      update = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 7) == 0) period = 16'($urandom_range(0, 12));
      if ($urandom_range(0, 5) == 0)
        set_act($urandom_range(0, 14), $urandom_range(0, 14),
                $urandom_range(0, 14), $urandom_range(0, 14));
      if ($urandom_range(0, 31) == 0) polarity = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 499) == 0) begin
        reset = 0;
        #1;
        model_reset();
        model_chk();
        reset = 1;
      end
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
